// File: rtl/tsi_io_conditioner.sv
// rtl/tsi_io_conditioner.sv - board I/O conditioning between FPGA pins and the emulated core
//
// Purpose: synchronises asynchronous board inputs, debounces switches, stretches
// reset and registers outputs with defined idle values, all in one clock domain.
//
// Optional feature macro: TSI_SW_DEBOUNCE_EN
//   defined   - per-bit switch debouncer honouring DEBOUNCE_CYCLES
//   undefined - synchronised switch value passes straight to o_SW
//
// Ports:
//   SYS_CLK   in   1          system clock (only clock)
//   SYS_RST   in   1          synchronous active-high reset for the whole block
//   i_RX      in   1          asynchronous UART RX pin
//   i_SW      in   SW_WIDTH   asynchronous switch pins
//   i_TX      in   1          core TX bit
//   i_LED     in   LED_WIDTH  core LED value
//   o_RST     out  1          stretched reset to the core
//   o_RX      out  1          synchronised RX
//   o_SW      out  SW_WIDTH   conditioned switch value
//   o_SW_CHG  out  SW_WIDTH   one-cycle per-bit pulse when an o_SW bit changes
//   o_TX      out  1          registered TX pin (idles at mark = 1)
//   o_LED     out  LED_WIDTH  registered LED pins

module tsi_io_conditioner #(
  parameter int SW_WIDTH        = 8,
  parameter int LED_WIDTH       = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RST_HOLD        = 16
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST,
  input  logic                 i_RX,
  input  logic [SW_WIDTH-1:0]  i_SW,
  input  logic                 i_TX,
  input  logic [LED_WIDTH-1:0] i_LED,
  output logic                 o_RST,
  output logic                 o_RX,
  output logic [SW_WIDTH-1:0]  o_SW,
  output logic [SW_WIDTH-1:0]  o_SW_CHG,
  output logic                 o_TX,
  output logic [LED_WIDTH-1:0] o_LED
);

  // Parameter sanity, caught at elaboration.
  if (SW_WIDTH < 1) begin : g_bad_sw_width
    $error("SW_WIDTH must be >= 1");
  end
  if (LED_WIDTH < 1) begin : g_bad_led_width
    $error("LED_WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (RST_HOLD < 0) begin : g_bad_rst_hold
    $error("RST_HOLD must be >= 0");
  end

  // ---------------------------------------------------------------------------
  // Reset stretcher. RST_HOLD=0 would need a zero-width counter; one bit that
  // always reloads to 0 gives the same one-cycle-delayed behaviour.
  // ---------------------------------------------------------------------------
  localparam int RST_CW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  logic [RST_CW-1:0] rst_cnt;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      rst_cnt <= RST_CW'(RST_HOLD);
      o_RST   <= 1'b1;
    end else if (rst_cnt != '0) begin
      rst_cnt <= rst_cnt - 1'b1;
      o_RST   <= 1'b1;
    end else begin
      o_RST   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser. Stages reset to 1 so the core sees an idle line.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] rx_sync;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      rx_sync <= '1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], i_RX};
    end
  end

  assign o_RX = rx_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Switch synchronisers, one chain per bit packed side by side.
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_sync [SYNC_STAGES];
  logic [SW_WIDTH-1:0] sw_s;

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sw_sync[i] <= '0;
      end
    end else begin
      sw_sync[0] <= i_SW;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sw_sync[i] <= sw_sync[i-1];
      end
    end
  end

  assign sw_s = sw_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Switch conditioning: sw_next is the value o_SW takes at the next edge.
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0] sw_next;

`ifdef TSI_SW_DEBOUNCE_EN
  localparam int DB_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_CW-1:0] DB_LAST = DB_CW'(DEBOUNCE_CYCLES - 1);

  logic [DB_CW-1:0] db_cnt      [SW_WIDTH];
  logic [DB_CW-1:0] db_cnt_next [SW_WIDTH];

  // A bit is accepted only after it has disagreed with o_SW for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    sw_next = o_SW;
    for (int b = 0; b < SW_WIDTH; b++) begin
      db_cnt_next[b] = db_cnt[b];
      if (sw_s[b] == o_SW[b]) begin
        db_cnt_next[b] = '0;
      end else if (db_cnt[b] == DB_LAST) begin
        sw_next[b]     = sw_s[b];
        db_cnt_next[b] = '0;
      end else begin
        db_cnt_next[b] = db_cnt[b] + 1'b1;
      end
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      for (int b = 0; b < SW_WIDTH; b++) begin
        db_cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < SW_WIDTH; b++) begin
        db_cnt[b] <= db_cnt_next[b];
      end
    end
  end
`else
  assign sw_next = sw_s;
`endif

  // Change pulse is registered alongside o_SW so both show up in the same cycle.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      o_SW     <= '0;
      o_SW_CHG <= '0;
    end else begin
      o_SW     <= sw_next;
      o_SW_CHG <= sw_next ^ o_SW;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers with idle values: TX at mark, LEDs off.
  // ---------------------------------------------------------------------------
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      o_TX  <= 1'b1;
      o_LED <= '0;
    end else begin
      o_TX  <= i_TX;
      o_LED <= i_LED;
    end
  end

endmodule

// File: tb/tb_tsi_io_conditioner.sv
// tb/tb_tsi_io_conditioner.sv - scoreboard bench for tsi_io_conditioner

module tb_tsi_io_conditioner;

  localparam int SW_W  = 4;
  localparam int LED_W = 8;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int HOLD  = 3;

`ifdef TSI_SW_DEBOUNCE_EN
  localparam int SW_LAT = SYNC + DEB;
`else
  localparam int SW_LAT = SYNC + 1;
`endif

  localparam int S_RST = 0;
  localparam int S_RX  = 1;
  localparam int S_SW  = 2;
  localparam int S_CHG = 3;
  localparam int S_TX  = 4;
  localparam int S_LED = 5;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             sys_rst;
  logic             rx;
  logic [SW_W-1:0]  sw;
  logic             tx;
  logic [LED_W-1:0] led;
  logic             o_rst;
  logic             o_rx;
  logic [SW_W-1:0]  o_sw;
  logic [SW_W-1:0]  o_sw_chg;
  logic             o_tx;
  logic [LED_W-1:0] o_led;

  int   edges    = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  tsi_io_conditioner #(
    .SW_WIDTH        (SW_W),
    .LED_WIDTH       (LED_W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .RST_HOLD        (HOLD)
  ) dut (
    .SYS_CLK  (clk),
    .SYS_RST  (sys_rst),
    .i_RX     (rx),
    .i_SW     (sw),
    .i_TX     (tx),
    .i_LED    (led),
    .o_RST    (o_rst),
    .o_RX     (o_rx),
    .o_SW     (o_sw),
    .o_SW_CHG (o_sw_chg),
    .o_TX     (o_tx),
    .o_LED    (o_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edges);
    end
  endtask

  function automatic logic [31:0] probe(input int sig);
    case (sig)
      S_RST:   return 32'(o_rst);
      S_RX:    return 32'(o_rx);
      S_SW:    return 32'(o_sw);
      S_CHG:   return 32'(o_sw_chg);
      S_TX:    return 32'(o_tx);
      default: return 32'(o_led);
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dly, input int sig, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = edges + dly;
    e.sig = sig;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic expect_sw(input int dly, input logic [31:0] s, input logic [31:0] c, input string tag);
    expect_at(dly, S_SW,  s, {tag, "_sw"});
    expect_at(dly, S_CHG, c, {tag, "_chg"});
  endtask

  // Compare everything due in this cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == edges) begin
        check(sb[i].tag, probe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    sys_rst = 1'b1;
    rx      = 1'b1;
    sw      = '0;
    tx      = 1'b1;
    led     = '0;

    // Reset state and release.
    tick(5);
    check("reset_o_rst", 32'(o_rst), 1);
    check("reset_o_rx", 32'(o_rx), 1);
    check("reset_o_sw", 32'(o_sw), 0);
    check("reset_o_sw_chg", 32'(o_sw_chg), 0);
    check("reset_o_tx", 32'(o_tx), 1);
    check("reset_o_led", 32'(o_led), 0);
    sys_rst = 1'b0;
    for (int k = 1; k <= HOLD; k++) expect_at(k, S_RST, 1, "release_hold");
    expect_at(HOLD + 1, S_RST, 0, "release_drop");
    for (int k = 1; k <= HOLD + 1; k++) begin
      expect_at(k, S_RX,  1, "release_rx");
      expect_at(k, S_TX,  1, "release_tx");
      expect_at(k, S_LED, 0, "release_led");
      expect_sw(k, 0, 0, "release");
    end
    tick(6);

    // Clean press on bit 0.
    sw = 4'b0001;
    expect_sw(SW_LAT - 1, 4'b0000, 4'b0000, "press_pre");
    expect_sw(SW_LAT,     4'b0001, 4'b0001, "press");
    expect_sw(SW_LAT + 1, 4'b0001, 4'b0000, "press_post");
    tick(SW_LAT + 3);

    // Three-cycle pulse on bit 2.
`ifdef TSI_SW_DEBOUNCE_EN
    for (int k = 1; k <= 10; k++) expect_sw(k, 4'b0001, 4'b0000, "glitch");
`else
    expect_sw(3, 4'b0101, 4'b0100, "glitch_in");
    expect_sw(4, 4'b0101, 4'b0000, "glitch_hold");
    expect_sw(6, 4'b0001, 4'b0100, "glitch_out");
    expect_sw(7, 4'b0001, 4'b0000, "glitch_post");
`endif
    sw = 4'b0101;
    tick(3);
    sw = 4'b0001;
    tick(10);

    // Clear bit 0, then reset in the middle of accepting bit 1.
    sw = 4'b0000;
    expect_sw(SW_LAT, 4'b0000, 4'b0001, "clear_b0");
    tick(SW_LAT + 2);
    sw = 4'b0010;
    tick(3);
    sys_rst = 1'b1;
    expect_at(1, S_RST, 1, "midrst_rst");
    expect_sw(1, 4'b0000, 4'b0000, "midrst");
    tick(1);
    sys_rst = 1'b0;
    for (int k = 1; k <= HOLD; k++) expect_at(k, S_RST, 1, "midrst_hold");
    expect_at(HOLD + 1, S_RST, 0, "midrst_drop");
    expect_sw(SW_LAT - 1, 4'b0000, 4'b0000, "reaccept_pre");
    expect_sw(SW_LAT,     4'b0010, 4'b0010, "reaccept");
    expect_sw(SW_LAT + 1, 4'b0010, 4'b0000, "reaccept_post");
    tick(SW_LAT + 3);

    // Registered outputs and RX synchroniser.
    led = 8'hA5;
    tx  = 1'b0;
    rx  = 1'b0;
    expect_at(0, S_LED, 32'h00, "led_old");
    expect_at(0, S_TX,  1, "tx_old");
    expect_at(1, S_LED, 32'hA5, "led_a5");
    expect_at(1, S_TX,  0, "tx_low");
    expect_at(1, S_RX,  1, "rx_sync1");
    expect_at(2, S_RX,  0, "rx_low");
    tick(3);
    led = 8'h3C;
    tx  = 1'b1;
    rx  = 1'b1;
    expect_at(1, S_LED, 32'h3C, "led_3c");
    expect_at(1, S_TX,  1, "tx_high");
    expect_at(1, S_RX,  0, "rx_sync1b");
    expect_at(2, S_RX,  1, "rx_high");
    tick(3);

    // Bit 3 alone, then several bits changing together.
    sw = 4'b0000;
    expect_sw(SW_LAT, 4'b0000, 4'b0010, "clear_b1");
    tick(SW_LAT + 2);
    sw = 4'b1000;
    expect_sw(SW_LAT - 1, 4'b0000, 4'b0000, "b3_pre");
    expect_sw(SW_LAT,     4'b1000, 4'b1000, "b3");
    expect_sw(SW_LAT + 1, 4'b1000, 4'b0000, "b3_post");
    tick(SW_LAT + 3);
    sw = 4'b0110;
    expect_sw(SW_LAT - 1, 4'b1000, 4'b0000, "multi_pre");
    expect_sw(SW_LAT,     4'b0110, 4'b1110, "multi");
    expect_sw(SW_LAT + 1, 4'b0110, 4'b0000, "multi_post");
    tick(SW_LAT + 3);

    tick(2);
    check("sb_drain", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
